// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   md_op_e    : operation encoding presented on the op port
//   md_state_e : sequencer states of mult_div_unit
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_sign_adjust.sv
// Converts the unsigned magnitude result of the iterative datapath into the
// final two's-complement HI/LO pair. Purely combinational.
//   is_mul : 1 = mag is a 2*WIDTH product, 0 = mag is {remainder, quotient}
//   neg_hi : remainder must be negated (divide only)
//   neg_lo : product (multiply) or quotient (divide) must be negated
//   mag    : magnitude result {upper, lower}
//   hi/lo  : signed result halves
module md_sign_adjust
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               is_mul,
    input  logic               neg_hi,
    input  logic               neg_lo,
    input  logic [2*WIDTH-1:0] mag,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;

    // A product is negated as one 2*WIDTH quantity so the borrow crosses halves.
    assign prod_s = neg_lo ? -mag : mag;
    assign quot_s = neg_lo ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
    assign rem_s  = neg_hi ? -mag[2*WIDTH-1:WIDTH] : mag[2*WIDTH-1:WIDTH];

    assign hi = is_mul ? prod_s[2*WIDTH-1:WIDTH] : rem_s;
    assign lo = is_mul ? prod_s[WIDTH-1:0]       : quot_s;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
//   clk, rst          : clock, synchronous active-high reset
//   start, op, a, b   : operation request (accepted only while idle)
//   flush             : abort the in-flight operation without a result
//   hi_we, lo_we      : direct HI/LO writes from wdata while idle
//   busy              : operation in flight (state != IDLE)
//   done, div_by_zero : one-cycle completion pulse and its zero-divisor flag
//   hi, lo            : product halves / remainder and quotient
module mult_div_unit
    import md_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_mul_q, is_mul_d;
    logic               neg_hi_q, neg_hi_d;
    logic               neg_lo_q, neg_lo_d;
    logic               zero_div_q, zero_div_d;
    // Multiplicand (multiply) or divisor (divide) magnitude.
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    // Operand decode for the start cycle.
    logic             op_signed, op_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign op_signed = (op == MD_MULT) || (op == MD_DIV);
    assign op_div    = (op == MD_DIV) || (op == MD_DIVU);
    assign a_neg     = op_signed & a[WIDTH-1];
    assign b_neg     = op_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                    + (prod_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

    // One restoring-divide step: bring down the next dividend bit and subtract
    // the divisor if it fits. The partial remainder stays below the divisor, so
    // a WIDTH-bit difference is exact whenever the subtraction is taken.
    logic [WIDTH:0]     div_part;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;

    assign div_part = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign div_ge   = div_part >= {1'b0, opnd_q};
    assign div_diff = div_part[WIDTH-1:0] - opnd_q;
    assign div_next = {(div_ge ? div_diff : div_part[WIDTH-1:0]),
                       prod_q[WIDTH-2:0], div_ge};

    logic [WIDTH-1:0] adj_hi, adj_lo;

    md_sign_adjust #(.WIDTH(WIDTH)) u_sign_adjust (
        .is_mul (is_mul_q),
        .neg_hi (neg_hi_q),
        .neg_lo (neg_lo_q),
        .mag    (prod_q),
        .hi     (adj_hi),
        .lo     (adj_lo)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_mul_d   = is_mul_q;
        neg_hi_d   = neg_hi_q;
        neg_lo_d   = neg_lo_q;
        zero_div_d = zero_div_q;
        opnd_d     = opnd_q;
        prod_d     = prod_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start && !flush) begin
                    cnt_d    = CNT_W'(WIDTH);
                    is_mul_d = !op_div;
                    state_d  = RUN;
                    if (op_div) begin
                        opnd_d     = b_mag;
                        prod_d     = {{WIDTH{1'b0}}, a_mag};
                        neg_lo_d   = a_neg ^ b_neg;
                        neg_hi_d   = a_neg;
                        zero_div_d = (b == '0);
                        if (b == '0) begin
                            // Keep the raw dividend; it is returned in HI.
                            prod_d  = {{WIDTH{1'b0}}, a};
                            state_d = FIN;
                        end
                    end else begin
                        opnd_d     = a_mag;
                        prod_d     = {{WIDTH{1'b0}}, b_mag};
                        neg_lo_d   = a_neg ^ b_neg;
                        neg_hi_d   = a_neg ^ b_neg;
                        zero_div_d = 1'b0;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    prod_d = is_mul_q ? mul_next : div_next;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
                if (!flush) begin
                    hi_d   = zero_div_q ? prod_q[WIDTH-1:0] : adj_hi;
                    lo_d   = zero_div_q ? {WIDTH{1'b1}} : adj_lo;
                    done_d = 1'b1;
                    dbz_d  = zero_div_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_mul_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            zero_div_q <= 1'b0;
            opnd_q     <= '0;
            prod_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_mul_q   <= is_mul_d;
            neg_hi_q   <= neg_hi_d;
            neg_lo_q   <= neg_lo_d;
            zero_div_q <= zero_div_d;
            opnd_q     <= opnd_d;
            prod_q     <= prod_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (WIDTH=32): a vector table run back to
// back, followed by hand-written flush, MTHI/MTLO and reset sequences.
module tb_mult_div_unit;
    import md_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, flush, hi_we, lo_we;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           busy_cyc;
    } vec_t;

    vec_t vecs[13];

    // Issue one operation at a negedge and wait for done (bounded).
    // Returns at the negedge of the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int busy_n, output bit seen);
        op = o; a = x; b = y; start = 1'b1;
        busy_n = 0; seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    // Watch for a given number of cycles and count done pulses.
    task automatic watch_no_done(input int n, output int dones);
        dones = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
    endtask

    initial begin
        int busy_n, dones;
        bit seen;
        logic [W-1:0] keep_hi, keep_lo;

        vecs[0]  = '{MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33};
        vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
        vecs[2]  = '{MD_DIVU,  32'h8000_0000, 32'h0000_0003, 32'h0000_0002, 32'h2AAA_AAAA, 1'b0, 33};
        vecs[3]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
        vecs[4]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33};
        vecs[5]  = '{MD_DIV,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1};
        vecs[6]  = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33};
        vecs[7]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33};
        vecs[8]  = '{MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 33};
        vecs[9]  = '{MD_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 33};
        vecs[10] = '{MD_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, 1'b0, 33};
        vecs[11] = '{MD_DIVU,  32'h0000_0003, 32'h0000_0000, 32'h0000_0003, 32'hFFFF_FFFF, 1'b1, 1};
        vecs[12] = '{MD_MULT,  32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 33};

        rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = MD_MULT; a = '0; b = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", W'(busy), '0);
        chk("reset_done", W'(done), '0);
        chk("reset_dbz", W'(div_by_zero), '0);
        chk("reset_hi", hi, '0);
        chk("reset_lo", lo, '0);
        rst = 1'b0;
        @(negedge clk);

        // Each vector after the first is started in the done cycle of the previous one.
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, busy_n, seen);
            $display("vec %0d op=%0d a=%08h b=%08h -> hi=%08h lo=%08h dbz=%0b busy=%0d done=%0b",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, div_by_zero, busy_n, seen);
            chk($sformatf("vec%0d_done", i), W'(seen), 1);
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
            chk($sformatf("vec%0d_dbz", i), W'(div_by_zero), W'(vecs[i].dbz));
            chk($sformatf("vec%0d_busy_cycles", i), W'(busy_n), W'(vecs[i].busy_cyc));
        end

        // done is a single-cycle pulse; div_by_zero holds after it.
        @(negedge clk);
        $display("after last vec: done=%0b busy=%0b", done, busy);
        chk("done_pulse_width", W'(done), '0);
        chk("idle_after_done", W'(busy), '0);
        keep_hi = hi; keep_lo = lo;

        // start together with flush while idle: start is ignored.
        op = MD_MULT; a = 32'd1; b = 32'd1; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        $display("idle start+flush: busy=%0b", busy);
        chk("idle_flush_start_busy", W'(busy), '0);

        // MULT 3x4, second start in RUN cycle 5 (ignored), flush in RUN cycle 10.
        op = MD_MULT; a = 32'd3; b = 32'd4; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 5) begin
                op = MD_DIVU; a = 32'd9; b = 32'd0; start = 1'b1;
            end
            if (k == 10) begin
                chk("busy_before_flush", W'(busy), 1);
                flush = 1'b1;
            end
        end
        @(negedge clk);
        flush = 1'b0;
        $display("flush: busy=%0b hi=%08h lo=%08h", busy, hi, lo);
        chk("busy_after_flush", W'(busy), '0);
        watch_no_done(45, dones);
        chk("flush_no_done", W'(dones), '0);
        chk("flush_hi_kept", hi, keep_hi);
        chk("flush_lo_kept", lo, keep_lo);

        // MTLO / MTHI while idle.
        lo_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        lo_we = 1'b0;
        $display("mtlo: lo=%08h hi=%08h", lo, hi);
        chk("mtlo_lo", lo, 32'h0000_1234);
        chk("mtlo_hi_kept", hi, keep_hi);
        hi_we = 1'b1; wdata = 32'h0000_ABCD;
        @(negedge clk);
        hi_we = 1'b0;
        $display("mthi: lo=%08h hi=%08h", lo, hi);
        chk("mthi_hi", hi, 32'h0000_ABCD);
        chk("mthi_lo_kept", lo, 32'h0000_1234);

        // hi_we while busy is ignored; the computed result lands.
        op = MD_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b1; wdata = 32'h5555_5555;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_busy_ignored", hi, 32'h0000_ABCD);
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        $display("multu 6x7 with busy mthi: hi=%08h lo=%08h done=%0b", hi, lo, seen);
        chk("busy_mthi_done", W'(seen), 1);
        chk("busy_mthi_hi", hi, '0);
        chk("busy_mthi_lo", lo, 32'd42);

        // Reset in the middle of a DIV.
        op = MD_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("mid-div reset: busy=%0b done=%0b dbz=%0b hi=%08h lo=%08h",
                 busy, done, div_by_zero, hi, lo);
        chk("rst_mid_busy", W'(busy), '0);
        chk("rst_mid_done", W'(done), '0);
        chk("rst_mid_dbz", W'(div_by_zero), '0);
        chk("rst_mid_hi", hi, '0);
        chk("rst_mid_lo", lo, '0);
        watch_no_done(45, dones);
        chk("rst_mid_no_done", W'(dones), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide execution unit with HI/LO result registers.
- Executes the MULT/MULTU/DIV/DIVU operations that the ALU control decode classes as multi-cycle.
- Sits beside the single-cycle ALU in the execute stage. The pipeline stalls on `busy`.
- Parametrised in datapath width. Adds a start/busy/done handshake, signed and unsigned modes, divide-by-zero flagging, flush, and direct HI/LO writes (MTHI/MTLO).

Parameters:
- WIDTH, 32, operand width in bits. Legal range is 4 or more. HI and LO are each WIDTH bits wide.
- CNT_W, $clog2(WIDTH+1), iteration-counter width. Derived; must not be overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only while idle
- op  in  2  operation: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- flush  in  1  abort the in-flight operation
- hi_we  in  1  write HI from wdata (MTHI)
- lo_we  in  1  write LO from wdata (MTLO)
- wdata  in  WIDTH  HI/LO write data
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; hi/lo valid in the same cycle
- div_by_zero  out  1  qualifies done; divisor was zero
- hi  out  WIDTH  upper product / remainder
- lo  out  WIDTH  lower product / quotient

Behaviour:
- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE, counter=0. Reset takes effect mid-operation: the unit returns to IDLE at the next edge and produces no done.
- States:
  - IDLE: start=1 at edge E0 latches magnitudes of a and b (signed ops), the result signs, and op. Counter is set to WIDTH. Next state is RUN. Exception: DIV/DIVU with b==0 goes straight to FIN.
  - RUN: one radix-2 step per cycle.
    - Multiply: shift-add into a 2*WIDTH accumulator.
    - Divide: restoring shift-subtract giving quotient and remainder.
    - Counter decrements each cycle. When it reaches 0 (edge E_WIDTH), next state is FIN.
  - FIN: applies signs, writes hi/lo, sets done=1 for exactly one cycle, then returns to IDLE.
- busy=1 in every cycle where state is not IDLE. Normal latency: busy is high for WIDTH+1 cycles; done and the new hi/lo appear in the first cycle after busy falls.
- Divide-by-zero path: busy is high for 1 cycle. Then hi=a (raw dividend), lo=all ones, and div_by_zero=1 together with done.
- div_by_zero stays 0 on every other done and holds its value until the next done.
- Arithmetic rules:
  - MULT: {hi,lo} = signed a × signed b, full 2*WIDTH bits.
  - MULTU: same, unsigned.
  - DIV: quotient truncates toward zero. Quotient sign = sign(a) XOR sign(b). Remainder takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Signed overflow (MIN / -1): lo=MIN, hi=0, no flag.
- Back-to-back: start may be asserted in the done cycle; it is accepted, because state is IDLE.
- start while busy: ignored, not queued.
- flush: when busy, the unit returns to IDLE at the next edge. hi/lo are unchanged and no done is produced. flush while idle has no effect; if start and flush occur together in IDLE, start is ignored.
- hi_we/lo_we: honoured only while busy=0, and take effect at the next edge. When busy=1 they are ignored, because the pipeline guarantees they do not occur then. If they coincide with the FIN edge, the computed result wins.

Decomposition:
- Shared package md_pkg:
  - op codes MD_MULT=2'd0, MD_MULTU=2'd1, MD_DIV=2'd2, MD_DIVU=2'd3
  - state enum IDLE/RUN/FIN
- One combinational sub-module, md_sign_adjust: takes the magnitude product, quotient and remainder, plus the sign bits, and produces the final two's-complement hi/lo. It is reused for both the multiply and divide paths.
- The FSM, counter and iteration datapath stay in mult_div_unit.

Test Plan (WIDTH=32):
- MULT a=0xFFFFFFFD, b=7 → after 33 busy cycles, done=1 with hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_by_zero=0.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then DIVU 0x80000000/3 started in the done cycle → lo=0x2AAAAAAA, hi=0x00000002.
- DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV a=5, b=0 → busy for 1 cycle, then done=1, div_by_zero=1, hi=5, lo=0xFFFFFFFF.
- MULT 3×4 with a second start at RUN cycle 5 and flush at RUN cycle 10 → no done. hi/lo keep their prior values. busy=0 one cycle after flush.
- lo_we with wdata=0x1234 while idle → lo=0x1234. Then rst asserted mid-DIV → all outputs return to 0 next cycle and no done follows.
